// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core memory path.
package mips_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StFault
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Core-request and waitrequest-bus signals of the memory port controller.
interface mem_bus_ctrl_if;

    logic        req;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    // The controller side
    modport slave (
        input  req, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  avm_readdata, avm_waitrequest,
        output stall, done, rdata, fault,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

    // The core plus memory side
    modport master (
        output req, req_write, req_byte, req_signed, req_addr, req_wdata,
        output avm_readdata, avm_waitrequest,
        input  stall, done, rdata, fault,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: read extraction with extension, write replication, byteenables.
module mem_byte_lane
    import mips_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    input  logic        signed_i,
    input  logic [31:0] readdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  byteenable_o
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte     = readdata_i[8*lane_i +: 8];
        rdata_o      = readdata_i;
        wdata_o      = wdata_i;
        byteenable_o = BE_WORD;
        if (byte_i) begin
            rdata_o      = {{24{signed_i & sel_byte[7]}}, sel_byte};
            wdata_o      = {4{wdata_i[7:0]}};
            byteenable_o = 4'(4'b0001 << lane_i);
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences single fetch/load/store requests onto a waitrequest-style bus.
module mem_bus_ctrl
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mem_bus_ctrl_if.slave  bus
);

    mem_state_t  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic        byte_q, byte_d;
    logic        signed_q, signed_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;

    logic [1:0]  lane_sel;
    logic        byte_sel;
    logic [31:0] lane_rdata;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;

    // In IDLE the lane logic serves the incoming request; otherwise the latched one.
    assign lane_sel = (state_q == StIdle) ? bus.req_addr[1:0] : lane_q;
    assign byte_sel = (state_q == StIdle) ? bus.req_byte : byte_q;

    mem_byte_lane u_lane (
        .lane_i       (lane_sel),
        .byte_i       (byte_sel),
        .signed_i     (signed_q),
        .readdata_i   (bus.avm_readdata),
        .wdata_i      (bus.req_wdata),
        .rdata_o      (lane_rdata),
        .wdata_o      (lane_wdata),
        .byteenable_o (lane_be)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        read_d   = read_q;
        write_d  = write_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (!bus.req_byte && (bus.req_addr[1:0] != 2'b00)) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else begin
                        lane_d   = bus.req_addr[1:0];
                        byte_d   = bus.req_byte;
                        signed_d = bus.req_signed;
                        addr_d   = {bus.req_addr[31:2], 2'b00};
                        be_d     = lane_be;
                        wd_d     = lane_wdata;
                        read_d   = !bus.req_write;
                        write_d  = bus.req_write;
                        state_d  = bus.req_write ? StWr : StRd;
                    end
                end
            end
            StRd: begin
                if (!bus.avm_waitrequest) begin
                    read_d  = 1'b0;
                    rdata_d = lane_rdata;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWr: begin
                if (!bus.avm_waitrequest) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lane_q   <= 2'b00;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wd_q     <= 32'h0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
        end
    end

    assign bus.stall          = (state_q != StIdle) || bus.req;
    assign bus.done           = done_q;
    assign bus.rdata          = rdata_q;
    assign bus.fault          = fault_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_write      = write_q;
    assign bus.avm_byteenable = be_q;
    assign bus.avm_writedata  = wd_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised transaction bench for mem_bus_ctrl with a per-cycle behavioural model.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle
    logic        e_stall, e_done, e_fault, e_read, e_write;
    logic [31:0] e_rdata, e_addr, e_wd;
    logic [3:0]  e_be;
    bit          pending_done;
    logic [31:0] pending_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(bit bt, bit sg, logic [1:0] a, logic [31:0] rd);
        logic [31:0] b;
        if (!bt) return rd;
        b = (rd >> (8 * a)) & 32'hFF;
        if (sg && b >= 32'd128) return b - 32'd256;
        return b;
    endfunction

    function automatic logic [3:0] model_be(bit bt, logic [1:0] a);
        if (!bt) return 4'hF;
        return 4'(2 ** int'(a));
    endfunction

    function automatic logic [31:0] model_wd(bit bt, logic [31:0] wd);
        if (!bt) return wd;
        return 32'h01010101 * {24'h0, wd[7:0]};
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("stall", 32'(bus.stall), 32'(e_stall));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("fault", 32'(bus.fault), 32'(e_fault));
            chk("avm_read", 32'(bus.avm_read), 32'(e_read));
            chk("avm_write", 32'(bus.avm_write), 32'(e_write));
            chk("rdata", bus.rdata, e_rdata);
            if (e_read || e_write) begin
                chk("avm_address", bus.avm_address, e_addr);
                chk("avm_byteenable", 32'(bus.avm_byteenable), 32'(e_be));
            end
            if (e_write) chk("avm_writedata", bus.avm_writedata, e_wd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.avm_waitrequest = 1'($urandom);
        bus.avm_readdata    = $urandom;
    endtask

    task automatic rand_req_fields();
        bus.req_write  = 1'($urandom);
        bus.req_byte   = 1'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic show_done();
        e_done = pending_done;
        if (pending_done) e_rdata = pending_rdata;
        pending_done = 1'b0;
    endtask

    task automatic idle();
        step();
        bus.req = 1'b0;
        rand_req_fields();
        e_stall = 1'b0;
        e_read  = 1'b0;
        e_write = 1'b0;
        show_done();
    endtask

    task automatic txn(input bit wr, input bit bt, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits);
        step();
        bus.req        = 1'b1;
        bus.req_write  = wr;
        bus.req_byte   = bt;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        show_done();
        e_stall = 1'b1;
        e_read  = 1'b0;
        e_write = 1'b0;
        if (!bt && addr[1:0] != 2'b00) return;
        for (int i = 0; i <= waits; i++) begin
            step();
            bus.req = 1'($urandom);
            rand_req_fields();
            bus.avm_waitrequest = (i < waits);
            if (i == waits) bus.avm_readdata = rd;
            e_stall = 1'b1;
            e_done  = 1'b0;
            e_read  = !wr;
            e_write = wr;
            e_addr  = {addr[31:2], 2'b00};
            e_be    = model_be(bt, addr[1:0]);
            e_wd    = model_wd(bt, wd);
        end
        pending_done  = 1'b1;
        pending_rdata = wr ? e_rdata : model_read(bt, sg, addr[1:0], rd);
    endtask

    task automatic fault_hold(input int n);
        repeat (n) begin
            step();
            bus.req = 1'($urandom);
            rand_req_fields();
            e_stall = 1'b1;
            e_fault = 1'b1;
            e_done  = 1'b0;
            e_read  = 1'b0;
            e_write = 1'b0;
        end
    endtask

    task automatic apply_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        e_done = 1'b0; e_rdata = 32'h0; e_fault = 1'b0;
        e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0;
        pending_done = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n   = 1'b1;
        bus.req = 1'b0;
        chk_en  = 1'b1;
    endtask

    initial begin
        bus.req = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.avm_readdata = 32'h0; bus.avm_waitrequest = 1'b0;
        e_addr = 32'h0; e_be = 4'h0; e_wd = 32'h0; pending_rdata = 32'h0;
        rst_n = 1'b0;
        #2;
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_fault", 32'(bus.fault), 32'h0);
        chk("reset_strobes", {30'h0, bus.avm_read, bus.avm_write}, 32'h0);
        chk("reset_address", bus.avm_address, 32'h0);
        chk("reset_be", 32'(bus.avm_byteenable), 32'h0);
        apply_reset();
        idle();

        // Word read, zero wait
        txn(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        idle();
        @(negedge clk);
        chk("lit_word_rdata", bus.rdata, 32'hDEADBEEF);
        chk("lit_word_done", 32'(bus.done), 32'h1);

        // Byte loads, signed then unsigned, from the top lane
        txn(1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 32'h80112233, 1);
        idle();
        @(negedge clk);
        chk("lit_lb_signed", bus.rdata, 32'hFFFFFF80);
        txn(1'b0, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80112233, 2);
        idle();
        @(negedge clk);
        chk("lit_lb_unsigned", bus.rdata, 32'h00000080);

        // Byte store with 3 wait cycles leaves rdata alone
        txn(1'b1, 1'b1, 1'b0, 32'h202, 32'h55, 32'h0, 3);
        idle();
        @(negedge clk);
        chk("lit_sb_rdata_kept", bus.rdata, 32'h00000080);
        chk("lit_sb_done", 32'(bus.done), 32'h1);

        // Back-to-back requests in the done cycle
        txn(1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h12345678, 1);
        txn(1'b1, 1'b0, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0, 0);
        txn(1'b0, 1'b1, 1'b1, 32'h405, 32'h0, 32'h00007F00, 0);
        idle();
        idle();

        // Misaligned word load traps
        txn(1'b0, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        fault_hold(4);
        @(negedge clk);
        chk("lit_fault_set", 32'(bus.fault), 32'h1);
        apply_reset();
        idle();
        @(negedge clk);
        chk("lit_fault_cleared", 32'(bus.fault), 32'h0);

        // Reset while a read is waiting
        txn(1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 32'hA5A5A5A5, 0);
        idle();
        step();
        bus.req = 1'b1; bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_addr = 32'h300;
        show_done();
        e_stall = 1'b1; e_read = 1'b0; e_write = 1'b0;
        step();
        bus.req = 1'b0;
        bus.avm_waitrequest = 1'b1;
        e_read = 1'b1; e_done = 1'b0; e_addr = 32'h300; e_be = 4'hF;
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("lit_rst_read_drop", 32'(bus.avm_read), 32'h0);
        apply_reset();
        idle();
        idle();
        @(negedge clk);
        chk("lit_rst_rdata_zero", bus.rdata, 32'h0);

        // Randomised traffic
        repeat (80) begin
            bit wr, bt, sg;
            logic [31:0] a;
            wr = 1'($urandom);
            bt = 1'($urandom);
            sg = 1'($urandom);
            a  = $urandom;
            if (!bt) a[1:0] = 2'b00;
            txn(wr, bt, sg, a, $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
